// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage integer/FP core: load-use stalls, branch flushes,
// WB->ID forwarding selects, multi-cycle FP sequencing. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       rs1_addr_ID,
    input  logic [5:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic             mc_start_ID,
    input  logic [5:0]       rd_addr_EX,
    input  logic             reg_write_EX,
    input  logic             mem_read_EX,
    input  logic [5:0]       rd_addr_WB,
    input  logic             reg_write_WB,
    input  logic             branch_taken_EX,
    input  logic             im_wait,
    input  logic             dm_wait,
    output logic [1:0]       busStall,
    output logic             stall_IF,
    output logic             bubble_EX,
    output logic             flush_ID,
    output logic             reg1_sel,
    output logic             reg2_sel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      perf_lu_cnt,
    output logic [31:0]      perf_bus_cnt,
    output logic [31:0]      perf_mc_cnt,
`endif
    output logic             mc_busy
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hold;
    logic             lu;
    logic             br;
    logic             mc_accept;

    // Back-end freeze: data bus wait, or a multi-cycle op still owning EX.
    always_comb begin
        hold     = dm_wait | ((state == MC_WAIT) && (cnt != '0));
        busStall = {hold, hold | im_wait};
    end

    always_comb begin
        lu = mem_read_EX && reg_write_EX && (rd_addr_EX != 6'd0) &&
             ((rs1_used_ID && (rs1_addr_ID == rd_addr_EX)) ||
              (rs2_used_ID && (rs2_addr_ID == rd_addr_EX)));
        br = branch_taken_EX;
    end

    // Taken branch wins over load-use; everything is deferred while the back end is frozen.
    always_comb begin
        flush_ID  = !hold && br;
        stall_IF  = !hold && !br && lu;
        bubble_EX = !hold && (br || lu);
    end

    always_comb begin
        reg1_sel = reg_write_WB && (rd_addr_WB != 6'd0) && rs1_used_ID && (rd_addr_WB == rs1_addr_ID);
        reg2_sel = reg_write_WB && (rd_addr_WB != 6'd0) && rs2_used_ID && (rd_addr_WB == rs2_addr_ID);
    end

    assign mc_accept = mc_start_ID && !busStall[0] && !stall_IF && !br && (MC_LAT > 32'd1);

    // Counter runs even under dm_wait; the op is released on the edge where it reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mc_accept) begin
                        state <= MC_WAIT;
                        cnt   <= CNT_W'(MC_LAT - 32'd1);
                    end
                end
                MC_WAIT: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign mc_busy = (state == MC_WAIT);

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_cnt  <= '0;
            perf_bus_cnt <= '0;
            perf_mc_cnt  <= '0;
        end else begin
            if (stall_IF)           perf_lu_cnt  <= perf_lu_cnt + 32'd1;
            if (dm_wait || im_wait) perf_bus_cnt <= perf_bus_cnt + 32'd1;
            if (mc_busy)            perf_mc_cnt  <= perf_mc_cnt + 32'd1;
        end
    end
`endif

endmodule
